pipelined_adder: RTL
====================

// Module: pipelined_adder
// PURPOSE
//  - Parametrised, pipelined ripple-carry adder/subtractor. Generalises the fixed
//    chained-8-bit adders to WIDTH bits split into WIDTH/CHUNK chunks, one chunk per stage.
//  - Valid/ready handshake on both sides, full-throughput streaming with backpressure.
//  - Arithmetic datapath primitive for the wide accumulators and the address generators.
// PARAMETERS
//  - WIDTH  32  operand/sum width; must be a multiple of CHUNK (elaboration error otherwise)
//  - CHUNK   8  bits added per pipeline stage; STAGES = WIDTH/CHUNK (1 to 16)
// PORTS
//  - clk        in   1      single clock, rising edge
//  - rst_n      in   1      asynchronous active-low reset
//  - in_valid   in   1      operand beat valid
//  - in_ready   out  1      block accepts a beat this cycle
//  - a          in   WIDTH  operand A
//  - b          in   WIDTH  operand B
//  - c_in       in   1      carry-in (add) / borrow-in (sub)
//  - sub        in   1      0: S=A+B+c_in, 1: S=A-B-c_in
//  - out_valid  out  1      result beat valid
//  - out_ready  in   1      downstream accepts result
//  - s          out  WIDTH  sum/difference, modulo 2^WIDTH
//  - c_out      out  1      carry out of the MSB (sub: 1 = no borrow)
//  - ovf        out  1      signed overflow; present only with PIPELINED_ADDER_OVF_EN
// BEHAVIOUR
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Sub mode: B inverted, effective carry-in = ~c_in (A + ~B + ~c_in); c_out is raw carry.
//  - Stage k (0..STAGES-1) adds chunk k using the registered carry from stage k-1.
//    Stage 0 uses the effective carry-in. Upper operand chunks travel in skew registers.
//    Lower result chunks travel in de-skew registers so that s leaves aligned.
//  - Latency: exactly STAGES cycles from accept to out_valid when there is no stall.
//    Throughput: one beat per cycle.
//  - Elastic stall: stage k advances when it is empty or stage k+1 advances; last stage
//    advances on out_ready.
//  - in_ready = ~stage0_valid | stage0_advances. This is combinational from out_ready
//    through the valid chain; no skid buffer.
//  - While out_valid & ~out_ready: s, c_out, ovf and out_valid hold stable.
//  - Bubbles do not take up throughput. A partly full pipe keeps filling under a stall.
//  - Reset (any time, incl. mid-stream): all stage valids=0, out_valid=0, s=0, c_out=0,
//    ovf=0, in_ready=1 in the first cycle after deassertion. In-flight beats are discarded.
//  - Wrap: 0xFFFF_FFFF+1 -> s=0, c_out=1. No saturation.
//  - STAGES=1 degenerates to a single registered adder with latency 1.
// CONFIGURATION
//  - PIPELINED_ADDER_OVF_EN defined: ovf port exists.
//    ovf = carry into MSB XOR carry out of MSB, aligned with s, reset 0.
//  - Not defined: ovf port and the MSB carry tap are absent. Everything else is identical.
// STRUCTURE
//  - pipelined_adder_pkg: STAGES function (WIDTH/CHUNK) and the WIDTH%CHUNK check macro.
//  - Sub-module adder_chunk: combinational CHUNK-bit adder (a,b,ci -> s,co,c_msb),
//    generated once per stage.
//  - Top holds the valid chain, skew/de-skew registers, carry registers and invert logic.
// TESTING (WIDTH=32, CHUNK=8, latency 4)
//  - Add: a=0x0000_00FF, b=0x1, c_in=0, sub=0 -> 4 cycles later s=0x0000_0100, c_out=0.
//  - Full carry ripple: a=0xFFFF_FFFF, b=0, c_in=1 -> s=0, c_out=1 (ovf=0).
//  - Sub: a=5, b=7, c_in=0, sub=1 -> s=0xFFFF_FFFE, c_out=0.
//    With OVF_EN: a=0x8000_0000, b=1, sub=1 -> s=0x7FFF_FFFF, ovf=1.
//  - Streaming: 100 random back-to-back beats with out_ready=1 -> in_ready stays 1, one
//    result per cycle, all match the reference model, in order.
//  - Backpressure: out_ready=0 for 10 cycles mid-stream -> exactly 4 beats held, in_ready=0
//    once full, s stable. On release no beats are lost or duplicated.
//  - Reset mid-stream with 3 beats in flight -> out_valid=0, s=0 at once. The first beat
//    after reset emerges 4 cycles after accept.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared sizing helpers and operation encoding for pipelined_adder.
// Also defines PIPELINED_ADDER_CHECK(W, C), which stops elaboration when W is not a
// whole multiple of C or when the stage count falls outside 1..MAX_STAGES.
`ifndef PIPELINED_ADDER_PKG_SV
`define PIPELINED_ADDER_PKG_SV

`define PIPELINED_ADDER_CHECK(W, C) \
    if ((((W) % (C)) != 0) || (((W) / (C)) < 1) || (((W) / (C)) > MAX_STAGES)) begin : g_cfg_error \
        $error("pipelined_adder: WIDTH must be a multiple of CHUNK giving 1..16 stages"); \
    end

package pipelined_adder_pkg;

    localparam int unsigned MAX_STAGES = 16;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int unsigned stages_of(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

`endif

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice used once per pipeline stage.
// With PIPELINED_ADDER_OVF_EN defined it also exposes the carry into its top bit.
module adder_chunk
#(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             c_msb
`endif
);

    logic [CHUNK:0] total;

    // Widened add so the chunk carry-out lands in the extra bit
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
        s     = total[CHUNK-1:0];
        co    = total[CHUNK];
    end

`ifdef PIPELINED_ADDER_OVF_EN
    // Carry into the top bit, recovered from that bit's operands and sum
    always_comb begin
        c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ total[CHUNK-1];
    end
`endif

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK-bit slice per stage, with an
// elastic valid/ready pipeline (no skid buffer, in_ready combinational from out_ready).
// Optional feature: define PIPELINED_ADDER_OVF_EN to add the signed-overflow port ovf.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned STAGES = stages_of(WIDTH, CHUNK);

    `PIPELINED_ADDER_CHECK(WIDTH, CHUNK)

    op_e              op;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] vld_in;
    logic [STAGES-1:0] adv;
    logic              all_full;
    logic [STAGES-1:0] cy_q;

    // Operands shift down one chunk per stage so the live chunk always sits at the
    // bottom; results enter at the top and shift down, ending aligned at the output.
    logic [WIDTH-1:0] opa_q  [STAGES];
    logic [WIDTH-1:0] opb_q  [STAGES];
    logic [WIDTH-1:0] res_q  [STAGES];
    logic [WIDTH-1:0] opa_in [STAGES];
    logic [WIDTH-1:0] opb_in [STAGES];
    logic [WIDTH-1:0] res_in [STAGES];

    logic [CHUNK-1:0]  ch_a [STAGES];
    logic [CHUNK-1:0]  ch_b [STAGES];
    logic [CHUNK-1:0]  ch_s [STAGES];
    logic [STAGES-1:0] ch_ci;
    logic [STAGES-1:0] ch_co;
`ifdef PIPELINED_ADDER_OVF_EN
    logic [STAGES-1:0] ch_msb;
    logic              ovf_q;
`endif

    // Subtraction as A + ~B + ~c_in
    always_comb begin
        op      = op_e'(sub);
        b_eff   = (op == OP_SUB) ? ~b : b;
        cin_eff = (op == OP_SUB) ? ~c_in : c_in;
    end

    // Stage k advances when any stage from k to the end is empty, or the output drains
    always_comb begin
        all_full = 1'b1;
        adv      = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            all_full               = all_full & vld[STAGES-1-i];
            adv[STAGES-1-i]        = out_ready | ~all_full;
        end
    end

    // Chunk adder inputs: stage 0 from the ports, later stages from the skew registers
    always_comb begin
        ch_a[0]  = a[CHUNK-1:0];
        ch_b[0]  = b_eff[CHUNK-1:0];
        ch_ci[0] = cin_eff;
        for (int unsigned k = 1; k < STAGES; k++) begin
            ch_a[k]  = opa_q[k-1][CHUNK-1:0];
            ch_b[k]  = opb_q[k-1][CHUNK-1:0];
            ch_ci[k] = cy_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        adder_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a    (ch_a[k]),
            .b    (ch_b[k]),
            .ci   (ch_ci[k]),
            .s    (ch_s[k]),
            .co   (ch_co[k])
`ifdef PIPELINED_ADDER_OVF_EN
            ,
            .c_msb(ch_msb[k])
`endif
        );
    end

    // Next-state values for the valid chain and the skew/de-skew registers
    always_comb begin
        vld_in[0]                   = in_valid;
        opa_in[0]                   = a >> CHUNK;
        opb_in[0]                   = b_eff >> CHUNK;
        res_in[0]                   = '0;
        res_in[0][WIDTH-1 -: CHUNK] = ch_s[0];
        for (int unsigned k = 1; k < STAGES; k++) begin
            vld_in[k]                   = vld[k-1];
            opa_in[k]                   = opa_q[k-1] >> CHUNK;
            opb_in[k]                   = opb_q[k-1] >> CHUNK;
            res_in[k]                   = res_q[k-1] >> CHUNK;
            res_in[k][WIDTH-1 -: CHUNK] = ch_s[k];
        end
    end

    // Each stage loads from its predecessor whenever it advances, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            cy_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k]   <= vld_in[k];
                    cy_q[k]  <= ch_co[k];
                    opa_q[k] <= opa_in[k];
                    opb_q[k] <= opb_in[k];
                    res_q[k] <= res_in[k];
                end
            end
        end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    // Overflow is captured alongside the final chunk so it stays aligned with s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv[STAGES-1]) begin
            ovf_q <= ch_msb[STAGES-1] ^ ch_co[STAGES-1];
        end
    end

    // Overflow output
    always_comb begin
        ovf = ovf_q;
    end
`endif

    // Handshake and result outputs
    always_comb begin
        in_ready  = adv[0];
        out_valid = vld[STAGES-1];
        s         = res_q[STAGES-1];
        c_out     = cy_q[STAGES-1];
    end

endmodule
